load_extend_ctrl: RTL

//  Load-unit sequencer in front of data memory for the RISC-V core. Accepts one load
//  (LB/LH/LW/LBU/LHU), checks alignment, issues a word-aligned memory read, waits for
//  the ack, then selects the byte/half lane, sign- or zero-extends it to 32 bits and

---
 rtl/load_extend_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/load_extend_ctrl.sv
// Load-unit sequencer: alignment check, word-aligned memory read, lane select and
// sign/zero extension. Optional WAIT timeout is enabled by defining LOAD_TIMEOUT_EN.
module load_extend_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  state_t      state, state_d;
  logic        req_ready_d, mem_req_d, rsp_valid_d, rsp_err_d;
  logic [31:0] mem_addr_d, rsp_data_d;
  logic [2:0]  funct3, funct3_d;
  logic [1:0]  lane, lane_d;
  logic        req_bad;
  logic        timeout_hit;

  function automatic logic [31:0] extend(input logic [2:0]  f3,
                                         input logic [1:0]  sel,
                                         input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{sel, 3'b000} +: 8];
    h = sel[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LBU:  r = {24'h0, b};
      F3_LHU:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  always_comb begin
    case (req_funct3)
      F3_LB, F3_LBU: req_bad = 1'b0;
      F3_LH, F3_LHU: req_bad = req_addr[0];
      F3_LW:         req_bad = (req_addr[1:0] != 2'b00);
      default:       req_bad = 1'b1;
    endcase
  end

`ifdef LOAD_TIMEOUT_EN
  localparam int CLOG = $clog2(TIMEOUT_CYCLES);
  localparam int CW   = (CLOG < 8) ? 8 : ((CLOG > 32) ? 32 : CLOG);

  logic [CW-1:0] cnt, cnt_d;

  // Clearing throughout IDLE guarantees a zero count on every WAIT entry.
  always_comb begin
    cnt_d = cnt;
    if (state == S_IDLE)
      cnt_d = '0;
    else if (state == S_WAIT && !mem_ack)
      cnt_d = cnt + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= cnt_d;
  end

  assign timeout_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign timeout_hit    = 1'b0;
`endif

  // NOTE: every output is computed here as a next value with defaults first, so no
  // path through the case leaves a variable unassigned (no latch) and all outputs
  // come straight from flops.
  always_comb begin
    state_d     = state;
    req_ready_d = req_ready;
    mem_req_d   = mem_req;
    mem_addr_d  = mem_addr;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    funct3_d    = funct3;
    lane_d      = lane;
    case (state)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready) begin
          req_ready_d = 1'b0;
          funct3_d    = req_funct3;
          lane_d      = req_addr[1:0];
          if (req_bad) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d    = S_WAIT;
            mem_req_d  = 1'b1;
            mem_addr_d = {req_addr[31:2], 2'b00};
          end
        end
      end
      S_WAIT: begin
        // A same-cycle ack takes priority over the timeout abort.
        if (mem_ack) begin
          state_d     = S_RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = extend(funct3, lane, mem_rdata);
        end else if (timeout_hit) begin
          state_d     = S_RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values; reset is synchronous and checked before the normal update.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      funct3    <= '0;
      lane      <= '0;
    end else begin
      state     <= state_d;
      req_ready <= req_ready_d;
      mem_req   <= mem_req_d;
      mem_addr  <= mem_addr_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      funct3    <= funct3_d;
      lane      <= lane_d;
    end
  end

endmodule
